csr_exec: RTL and testbench
===========================

CSR_EXEC -- requirements
Module: csr_exec

Interface
REQ-001 The block SHALL have no parameters; XLEN, the csr_op_e enumeration and the exception-cause constants SHALL come from offnariscv_pkg.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  a CSR instruction is offered.
REQ-006 in_ready  output  1  the block accepts the offered instruction.
REQ-007 in_op  input  csr_op_e (2)  operation: CSR_RW, CSR_RS or CSR_RC.
REQ-008 in_addr  input  12  CSR address.
REQ-009 in_src  input  XLEN  operand: rs1 value, or uimm zero-extended by the decoder.
REQ-010 in_src_zero  input  1  the rs1 index or uimm field is zero.
REQ-011 in_rd  input  5  destination register index.
REQ-012 flush  input  1  pipeline flush.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 out_rdata  output  XLEN  old CSR value.
REQ-015 out_rd  output  5  destination register index.
REQ-016 out_we  output  1  register-file write enable.
REQ-017 out_exc  output  1  an exception was raised.
REQ-018 out_cause  output  XLEN  exception cause.
REQ-019 csr_rif_req  modport  -  CSR read port: drives addr; samples rdata, ro and exception.
REQ-020 csr_wif_req  modport  -  CSR write port: drives valid, addr and data.

Function
REQ-021 The FSM SHALL have the states IDLE, EXEC and RESP; in_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, when in_valid && in_ready, the block SHALL latch op, addr, src, src_zero and rd, then go to EXEC.
REQ-023 In EXEC, csr_rif addr SHALL be the latched addr; the read is combinational and its rdata SHALL be captured into the result register at the end of EXEC.
REQ-024 new value: RW = src; RS = old | src; RC = old & ~src; the computation SHALL be full XLEN width with no carries.
REQ-025 write_intent = (op == RW) || !src_zero.
REQ-026 illegal = (write_intent && ro) || exception from csr_rif.
REQ-027 csr_wif valid SHALL be 1 for exactly the single EXEC cycle when write_intent && !illegal && !flush, with addr and data equal to the latched addr and the new value; it SHALL be 0 in every other cycle.
REQ-028 EXEC SHALL last one cycle, then go to RESP; if flush is 1 in EXEC, the block SHALL instead go to IDLE with no write and no response.
REQ-029 In RESP, out_valid SHALL be 1 and all out_* outputs SHALL be held stable until out_ready; on out_valid && out_ready the block SHALL go to IDLE.
REQ-030 out_we = !illegal && (rd != 0); out_exc = illegal; out_cause = EXC_ILLEGAL_INSN (2) when illegal, else 0; out_rdata = 0 when illegal.
REQ-031 A flush in RESP SHALL drop out_valid and return the block to IDLE; the completed write is not undone.
REQ-032 A flush in IDLE SHALL have no effect, and an instruction offered in that cycle SHALL NOT be accepted.
REQ-033 Latency: accept at cycle N, write at N+1, out_valid at N+2; throughput is at most one instruction per 3 cycles.

Reset
REQ-034 When rst_n is low, the block SHALL be in IDLE with out_valid=0, out_we=0, out_exc=0, out_cause=0, out_rdata=0, out_rd=0 and csr_wif valid=0.
REQ-035 Assertion of rst_n in EXEC or RESP SHALL abort the operation immediately, with no write issued after the assertion.

Structure
REQ-036 csr_op_e, csr_exec_state_e and EXC_ILLEGAL_INSN SHALL be placed in offnariscv_pkg.
REQ-037 The new-value computation SHALL be one combinational sub-module, csr_alu (inputs op, old, src; output new).

Verification
REQ-038 CSRRW to 0x305 with src=0x8000_0104, rd=5 -> one write pulse with data 0x8000_0104; out_rdata = old mtvec; out_we=1; rd=5.
REQ-039 CSRRS to 0x342 with old=0x0F and src=0xF0 -> write 0xFF; CSRRC with src=0x0F -> write 0xF0.
REQ-040 CSRRS to 0xF14 with src_zero=1 -> no write pulse, out_rdata = MHARTID, out_exc=0; CSRRW to 0xF14 -> out_exc=1, cause=2, out_we=0, no write.
REQ-041 out_ready held low for 5 cycles in RESP -> out_* stable, in_ready=0 throughout; exactly one write observed.
REQ-042 flush in EXEC -> no write and no out_valid; rst_n asserted in RESP -> out_valid=0 immediately, next instruction accepted after release.

Source files
------------

// File: rtl/offnariscv_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : offnariscv_pkg                                                    |
// | Brief  : Shared types and constants for the CSR execution unit.            |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package offnariscv_pkg;

  localparam int unsigned XLEN = 32;

  // Encoding follows funct3[1:0] of the Zicsr instructions.
  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } csr_exec_state_e;

  localparam logic [XLEN-1:0] EXC_ILLEGAL_INSN = XLEN'(2);

endpackage

`default_nettype wire

// File: rtl/csr_exec_if.sv
// +----------------------------------------------------------------------------+
// | Module : csr_rif_if / csr_wif_if                                           |
// | Brief  : CSR file read port (combinational) and write port.                |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface csr_rif_if;
  import offnariscv_pkg::*;

  logic [11:0]     addr;
  logic [XLEN-1:0] rdata;
  logic            ro;
  logic            exception;

  modport req (output addr, input rdata, ro, exception);
  modport rsp (input addr, output rdata, ro, exception);
endinterface

interface csr_wif_if;
  import offnariscv_pkg::*;

  logic            valid;
  logic [11:0]     addr;
  logic [XLEN-1:0] data;

  modport req (output valid, addr, data);
  modport rsp (input valid, addr, data);
endinterface

`default_nettype wire

// File: rtl/csr_alu.sv
// +----------------------------------------------------------------------------+
// | Module : csr_alu                                                           |
// | Brief  : New CSR value from old value and operand (bitwise, no carries).   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module csr_alu
  import offnariscv_pkg::*;
(
  input  csr_op_e         op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = src_i;
    case (op_i)
      CSR_RS:  new_o = old_i | src_i;
      CSR_RC:  new_o = old_i & ~src_i;
      default: new_o = src_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/csr_exec.sv
// +----------------------------------------------------------------------------+
// | Module : csr_exec                                                          |
// | Brief  : Zicsr execution unit: IDLE -> EXEC (read/write) -> RESP.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module csr_exec
  import offnariscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  csr_op_e         in_op,
  input  logic [11:0]     in_addr,
  input  logic [XLEN-1:0] in_src,
  input  logic            in_src_zero,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_exc,
  output logic [XLEN-1:0] out_cause,
  csr_rif_if.req          csr_rif,
  csr_wif_if.req          csr_wif
);

  csr_exec_state_e state_q, state_d;
  csr_op_e         op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] src_q, src_d;
  logic            src_zero_q, src_zero_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic            we_q, we_d;
  logic            exc_q, exc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  logic            write_intent;
  logic            illegal;
  logic [XLEN-1:0] new_val;

  csr_alu u_alu (
    .op_i  (op_q),
    .old_i (csr_rif.rdata),
    .src_i (src_q),
    .new_o (new_val)
  );

  assign csr_rif.addr = addr_q;
  assign csr_wif.addr = addr_q;
  assign csr_wif.data = new_val;

  // A set/clear with a zero operand is a pure read, so it is legal on read-only CSRs.
  assign write_intent = (op_q == CSR_RW) || !src_zero_q;
  assign illegal      = (write_intent && csr_rif.ro) || csr_rif.exception;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    src_d         = src_q;
    src_zero_d    = src_zero_q;
    rd_d          = rd_q;
    rdata_d       = rdata_q;
    res_rd_d      = res_rd_q;
    we_d          = we_q;
    exc_d         = exc_q;
    cause_d       = cause_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    csr_wif.valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) begin
          op_d       = in_op;
          addr_d     = in_addr;
          src_d      = in_src;
          src_zero_d = in_src_zero;
          rd_d       = in_rd;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          csr_wif.valid = write_intent && !illegal;
          rdata_d       = illegal ? '0 : csr_rif.rdata;
          res_rd_d      = rd_q;
          we_d          = !illegal && (rd_q != 5'd0);
          exc_d         = illegal;
          cause_d       = illegal ? EXC_ILLEGAL_INSN : '0;
          state_d       = RESP;
        end
      end
      RESP: begin
        out_valid = !flush;
        if (flush || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= CSR_RW;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      rd_q       <= '0;
      rdata_q    <= '0;
      res_rd_q   <= '0;
      we_q       <= 1'b0;
      exc_q      <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      res_rd_q   <= res_rd_d;
      we_q       <= we_d;
      exc_q      <= exc_d;
      cause_q    <= cause_d;
    end
  end

  assign out_rdata = rdata_q;
  assign out_rd    = res_rd_q;
  assign out_we    = we_q;
  assign out_exc   = exc_q;
  assign out_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_exec.sv
// +----------------------------------------------------------------------------+
// | Module : tb_csr_exec                                                       |
// | Brief  : Scoreboard bench for csr_exec with a small CSR file model.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_csr_exec;
  import offnariscv_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [31:0] cause;
  } rsp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  csr_op_e     in_op = CSR_RW;
  logic [11:0] in_addr = '0;
  logic [31:0] in_src = '0;
  logic        in_src_zero = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_exc;
  logic [31:0] out_cause;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;

  rsp_t exp_rsp_q[$];
  wr_t  exp_wr_q[$];

  logic [31:0] csr_file [4];
  logic [31:0] ref_csr  [4];
  int          rd_idx;

  csr_rif_if rif ();
  csr_wif_if wif ();

  always #5 clk = ~clk;

  csr_exec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_addr     (in_addr),
    .in_src      (in_src),
    .in_src_zero (in_src_zero),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_exc     (out_exc),
    .out_cause   (out_cause),
    .csr_rif     (rif),
    .csr_wif     (wif)
  );

  function automatic int csr_idx(logic [11:0] a);
    case (a)
      12'h305: return 0;  // mtvec
      12'h340: return 1;  // mscratch
      12'h342: return 2;  // mcause
      12'hF14: return 3;  // mhartid
      default: return -1;
    endcase
  endfunction

  // CSR file seen by the DUT
  assign rd_idx        = csr_idx(rif.addr);
  assign rif.rdata     = (rd_idx >= 0) ? csr_file[rd_idx[1:0]] : 32'h0;
  assign rif.ro        = (rif.addr[11:10] == 2'b11);
  assign rif.exception = (rd_idx < 0);

  always @(posedge clk) begin : csr_wr
    int wi;
    wi = csr_idx(wif.addr);
    if (wif.valid && wi >= 0 && wif.addr[11:10] != 2'b11) csr_file[wi[1:0]] <= wif.data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wif.valid) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          chk("wr_addr", {20'h0, wif.addr}, {20'h0, w.addr});
          chk("wr_data", wif.data, w.data);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          rsp_t r;
          r = exp_rsp_q.pop_front();
          chk("rsp_rdata", out_rdata, r.rdata);
          chk("rsp_rd", {27'h0, out_rd}, {27'h0, r.rd});
          chk("rsp_we", {31'h0, out_we}, {31'h0, r.we});
          chk("rsp_exc", {31'h0, out_exc}, {31'h0, r.exc});
          chk("rsp_cause", out_cause, r.cause);
        end
      end
    end
  end

  // mode 0: normal, 1: flush during EXEC, 2: stall in RESP (returns at a RESP negedge)
  task automatic issue(input csr_op_e op, input logic [11:0] addr, input logic [31:0] src,
                       input logic sz, input logic [4:0] rd, input int mode);
    int          ci;
    int          guard;
    logic [31:0] old;
    logic [31:0] nv;
    logic        wi, ill, ew;
    rsp_t        r;
    wr_t         w;
    ci   = csr_idx(addr);
    old  = (ci >= 0) ? ref_csr[ci] : 32'h0;
    wi   = (op == CSR_RW) || !sz;
    ill  = (wi && (addr[11:10] == 2'b11)) || (ci < 0);
    case (op)
      CSR_RS:  nv = old | src;
      CSR_RC:  nv = old & ~src;
      default: nv = src;
    endcase
    ew = wi && !ill && (mode != 1);
    if (ew) begin
      w.addr = addr; w.data = nv;
      exp_wr_q.push_back(w);
      ref_csr[ci] = nv;
    end
    if (mode != 1) begin
      r.rdata = ill ? 32'h0 : old;
      r.rd    = rd;
      r.we    = !ill && (rd != 5'd0);
      r.exc   = ill;
      r.cause = ill ? 32'd2 : 32'd0;
      exp_rsp_q.push_back(r);
    end
    out_ready = (mode != 2);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1; in_op = op; in_addr = addr; in_src = src; in_src_zero = sz; in_rd = rd;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (mode == 1) flush = 1'b1;
    @(negedge clk);
    chk("exec_in_ready", {31'h0, in_ready}, 32'd0);
    chk("exec_wr_pulse", {31'h0, wif.valid}, {31'h0, ew});
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", {31'h0, out_valid}, (mode != 1) ? 32'd1 : 32'd0);
    if (mode != 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    csr_file[0] = 32'h0000_0100; csr_file[1] = 32'hDEAD_BEEF;
    csr_file[2] = 32'h0000_000F; csr_file[3] = 32'h0000_0007;
    ref_csr[0]  = 32'h0000_0100; ref_csr[1]  = 32'hDEAD_BEEF;
    ref_csr[2]  = 32'h0000_000F; ref_csr[3]  = 32'h0000_0007;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_we", {31'h0, out_we}, 32'd0);
    chk("rst_out_exc", {31'h0, out_exc}, 32'd0);
    chk("rst_out_cause", out_cause, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_rd", {27'h0, out_rd}, 32'd0);
    chk("rst_wr_valid", {31'h0, wif.valid}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(CSR_RW, 12'h305, 32'h8000_0104, 1'b0, 5'd5, 0);
    issue(CSR_RS, 12'h342, 32'h0000_00F0, 1'b0, 5'd3, 0);
    issue(CSR_RC, 12'h342, 32'h0000_000F, 1'b0, 5'd0, 0);
    issue(CSR_RS, 12'hF14, 32'h0000_0000, 1'b1, 5'd7, 0);
    issue(CSR_RW, 12'hF14, 32'h0000_0055, 1'b0, 5'd8, 0);
    issue(CSR_RS, 12'h7C0, 32'h0000_0000, 1'b1, 5'd4, 0);
    issue(CSR_RC, 12'h340, 32'h0000_0000, 1'b1, 5'd6, 0);
    issue(CSR_RW, 12'h305, 32'hFFFF_FFFF, 1'b0, 5'd31, 0);

    // Stall in RESP for several cycles
    wr_before = wr_seen;
    issue(CSR_RW, 12'h340, 32'h0000_1234, 1'b0, 5'd9, 2);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'h0, out_valid}, 32'd1);
      chk("stall_rdata", out_rdata, exp_rsp_q[0].rdata);
      chk("stall_rd", {27'h0, out_rd}, {27'h0, exp_rsp_q[0].rd});
      chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_wr_count", wr_seen - wr_before, 32'd1);

    // Flush during EXEC
    wr_before = wr_seen;
    issue(CSR_RW, 12'h340, 32'hCAFE_0000, 1'b0, 5'd10, 1);
    repeat (3) @(negedge clk);
    chk("flush_exec_no_wr", wr_seen - wr_before, 32'd0);
    chk("flush_exec_no_valid", {31'h0, out_valid}, 32'd0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = CSR_RW; in_addr = 12'h340; in_src = 32'h1; in_rd = 5'd1;
    #1 chk("flush_idle_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_wr", {31'h0, wif.valid}, 32'd0);
    chk("flush_idle_state", {31'h0, in_ready}, 32'd1);

    // Reset asserted while in RESP
    issue(CSR_RS, 12'h342, 32'h0000_0100, 1'b0, 5'd11, 2);
    #2 rst_n = 1'b0;
    #1 chk("rst_resp_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_resp_wr", {31'h0, wif.valid}, 32'd0);
    chk("rst_resp_we", {31'h0, out_we}, 32'd0);
    exp_rsp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(CSR_RS, 12'h342, 32'h0000_0000, 1'b1, 5'd12, 0);

    // Flush while in RESP
    issue(CSR_RC, 12'h305, 32'h0000_00FF, 1'b0, 5'd13, 2);
    @(posedge clk);
    #1 flush = 1'b1;
    void'(exp_rsp_q.pop_front());
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_resp_valid", {31'h0, out_valid}, 32'd0);
    chk("flush_resp_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;

    issue(CSR_RS, 12'h305, 32'h0000_0000, 1'b1, 5'd14, 0);

    repeat (2) @(negedge clk);
    chk("rsp_q_empty", exp_rsp_q.size(), 32'd0);
    chk("wr_q_empty", exp_wr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
